fp32_minmax_acc: RTL and testbench
==================================

# fp32_minmax_acc

Streaming single-precision min/max reducer that sits directly downstream of the team's fp32 magnitude comparator. It consumes a framed stream of fp32 values over a valid/ready handshake and uses two comparator instances per beat, one against the running minimum and one against the running maximum. At end of frame it emits the minimum, the maximum, their element indices, the element count and a NaN-seen flag as one result beat.

## Interface

Parameters:
- IDX_W, 16, width of element index and count fields.

Ports:
- clk, in, 1, sole clock; all state updates on rising edge.
- rst, in, 1, synchronous, active-high reset.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, block can accept an input beat.
- s_data, in, 32, fp32 element.
- s_last, in, 1, marks the final element of a frame.
- m_valid, out, 1, result beat valid.
- m_ready, in, 1, downstream accepts result.
- m_min, out, 32, smallest non-NaN element of the frame.
- m_max, out, 32, largest non-NaN element of the frame.
- m_min_idx, out, IDX_W, index of m_min within the frame, 0-based.
- m_max_idx, out, IDX_W, index of m_max within the frame, 0-based.
- m_count, out, IDX_W, number of elements in the frame, saturating.
- m_nan_seen, out, 1, at least one NaN element was in the frame.

## Operation

- Two states: ACC, which accepts input, and HOLD, which presents the result. Reset enters ACC with the frame empty.
- s_ready = 1 in ACC and 0 in HOLD. m_valid = 1 only in HOLD.
- An input beat is accepted when s_valid and s_ready are both high.
- Element index equals the count of beats already accepted in the current frame. Both index and count saturate at 2^IDX_W−1 and never wrap.
- NaN element (exponent 0xFF, mantissa ≠ 0):
  - sets the nan flag;
  - is counted;
  - does not update min or max.
- First non-NaN element of a frame loads both min and max and both indices.
- Later non-NaN elements:
  - update min only when the comparator reports elem lt min;
  - update max only when the comparator reports elem gt max.
- Ties keep the earlier index. This includes −0 vs +0, which compare equal, so the earlier zero and its sign are kept.
- Infinities compare normally.
- All-NaN frame: m_min = m_max = 0x7FC00000, both indices 0, m_nan_seen = 1.
- Accepted beat with s_last = 1: the accumulation includes that beat, the result registers load, and the state goes to HOLD.
- In HOLD, when m_valid and m_ready are both high: return to ACC and clear the frame accumulators. Result outputs hold their values until the next frame completes.
- rst mid-frame or mid-HOLD discards all partial or pending results.

## Timing

- Reset values:
  - s_ready = 1;
  - m_valid = 0, m_min = 0, m_max = 0, m_min_idx = 0, m_max_idx = 0, m_count = 0, m_nan_seen = 0.
- Throughput: one element per cycle in ACC.
- Latency: last beat accepted at edge N, m_valid = 1 from cycle N+1.
- Result accepted at edge M: s_ready = 1 from cycle M+1. This gives one bubble cycle between frames.
- Outputs are registered. Comparator logic is combinational between the s_data input and the accumulator registers.
- m_* are stable while m_valid = 1 and m_ready = 0.

## Configuration

- FP32_MINMAX_NAN_PROP_EN defined: any NaN in the frame forces m_min = m_max = 0x7FC00000. Indices report the first NaN's index; m_nan_seen = 1.
- Undefined: NaNs are skipped as described in Operation. m_nan_seen still reports them.

## Test plan

- Frame [1.0, −2.0, 3.5, 0.5(last)], m_ready = 1:
  - m_min = 0xC0000000, idx 1;
  - m_max = 0x40600000, idx 2;
  - count 4, nan 0;
  - m_valid exactly one cycle after the last beat.
- Frame [+0 (0x00000000), −0 (0x80000000)(last)] → m_min = m_max = 0x00000000, both idx 0.
- Frame [NaN 0x7FC00001, 2.0, −inf 0xFF800000(last)]:
  - without macro: min = 0xFF800000 idx 2, max = 0x40000000 idx 1, nan 1, count 3;
  - with macro: min = max = 0x7FC00000, idx 0.
- Single-element frame [5.0 last]; hold m_ready = 0 for 5 cycles → s_ready = 0 and outputs stable throughout. Handshake → s_ready = 1 next cycle.
- Assert rst after 2 beats of a frame, then send [7.0 last] → result min = max = 7.0, count 1, idx 0.
- Frame of 2^IDX_W+3 beats of 1.0 → count saturates at 0xFFFF, min_idx = max_idx = 0.

Source files
------------

// File: rtl/fp32_minmax_acc_if.sv
// ---------------------------------------------------------------------------
// fp32_minmax_acc_if
//   Bundles the input element stream and the result beat of fp32_minmax_acc.
//
//   Input stream : s_valid, s_ready, s_data[31:0], s_last
//   Result beat  : m_valid, m_ready, m_min, m_max, m_min_idx, m_max_idx,
//                  m_count, m_nan_seen
//
//   Modports:
//     slave  - the reducer (consumes s_*, produces m_*)
//     master - the environment (produces s_*, consumes m_*)
// ---------------------------------------------------------------------------
interface fp32_minmax_acc_if #(
    parameter int IDX_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_min;
    logic [31:0]      m_max;
    logic [IDX_W-1:0] m_min_idx;
    logic [IDX_W-1:0] m_max_idx;
    logic [IDX_W-1:0] m_count;
    logic             m_nan_seen;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx,
               m_count, m_nan_seen
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx,
               m_count, m_nan_seen
    );
endinterface

// File: rtl/fp32_minmax_acc.sv
// ---------------------------------------------------------------------------
// fp32_minmax_acc
//   Streaming fp32 min/max reducer. Accepts one element per cycle while in
//   ACC, and at the end of a frame presents min, max, their 0-based indices,
//   the saturating element count and a NaN-seen flag as one result beat
//   (HOLD). One bubble cycle separates frames.
//
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - synchronous active-high reset
//     bus  - fp32_minmax_acc_if.slave (s_* element stream, m_* result beat)
//
//   Optional feature macro: FP32_MINMAX_NAN_PROP_EN
//     defined   : any NaN in the frame forces min = max = 0x7FC00000 and
//                 both indices report the first NaN's index.
//     undefined : NaNs are skipped for min/max, still flagged in m_nan_seen.
// ---------------------------------------------------------------------------
module fp32_minmax_acc #(
    parameter int IDX_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp32_minmax_acc_if.slave     bus
);

    localparam logic [0:0]       ST_ACC  = 1'b0;
    localparam logic [0:0]       ST_HOLD = 1'b1;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    // Ordering key: monotonic unsigned mapping of fp32 bit patterns.
    function automatic logic [31:0] fp_key(input logic [31:0] v);
        fp_key = v[31] ? ~v : {1'b1, v[30:0]};
    endfunction

    // Comparator: a < b for non-NaN operands; -0 and +0 compare equal.
    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            fp_lt = 1'b0;
        end else begin
            fp_lt = fp_key(a) < fp_key(b);
        end
    endfunction

    logic [0:0]       state_r;
    logic [31:0]      acc_min_r, acc_max_r;
    logic [IDX_W-1:0] acc_min_idx_r, acc_max_idx_r, acc_count_r, acc_nan_idx_r;
    logic             acc_have_r, acc_nan_r;

    logic [31:0]      res_min_r, res_max_r;
    logic [IDX_W-1:0] res_min_idx_r, res_max_idx_r, res_count_r;
    logic             res_nan_r;

    logic             is_nan_s, accept_s;
    logic [31:0]      nxt_min_s, nxt_max_s;
    logic [IDX_W-1:0] nxt_min_idx_s, nxt_max_idx_s, nxt_count_s, nxt_nan_idx_s;
    logic             nxt_have_s, nxt_nan_s;
    logic [31:0]      fin_min_s, fin_max_s;
    logic [IDX_W-1:0] fin_min_idx_s, fin_max_idx_s;

    assign is_nan_s = (bus.s_data[30:23] == 8'hFF) && (bus.s_data[22:0] != 23'd0);
    assign accept_s = bus.s_valid && (state_r == ST_ACC);

    // Fold the current input element into the running accumulators.
    always_comb begin
        nxt_min_s     = acc_min_r;
        nxt_max_s     = acc_max_r;
        nxt_min_idx_s = acc_min_idx_r;
        nxt_max_idx_s = acc_max_idx_r;
        nxt_have_s    = acc_have_r;
        nxt_nan_s     = acc_nan_r;
        nxt_nan_idx_s = acc_nan_idx_r;
        // Element index is the pre-increment count, so it saturates with it.
        if (acc_count_r == IDX_MAX) begin
            nxt_count_s = acc_count_r;
        end else begin
            nxt_count_s = acc_count_r + IDX_W'(1);
        end
        if (is_nan_s) begin
            nxt_nan_s = 1'b1;
            if (!acc_nan_r) begin
                nxt_nan_idx_s = acc_count_r;
            end else begin
                nxt_nan_idx_s = acc_nan_idx_r;
            end
        end else if (!acc_have_r) begin
            nxt_have_s    = 1'b1;
            nxt_min_s     = bus.s_data;
            nxt_max_s     = bus.s_data;
            nxt_min_idx_s = acc_count_r;
            nxt_max_idx_s = acc_count_r;
        end else begin
            // Strict comparisons: ties keep the earlier element.
            if (fp_lt(bus.s_data, acc_min_r)) begin
                nxt_min_s     = bus.s_data;
                nxt_min_idx_s = acc_count_r;
            end else begin
                nxt_min_s     = acc_min_r;
                nxt_min_idx_s = acc_min_idx_r;
            end
            if (fp_lt(acc_max_r, bus.s_data)) begin
                nxt_max_s     = bus.s_data;
                nxt_max_idx_s = acc_count_r;
            end else begin
                nxt_max_s     = acc_max_r;
                nxt_max_idx_s = acc_max_idx_r;
            end
        end
    end

    // Final result values for a frame that ends with the current element.
    always_comb begin
        fin_min_s     = QNAN;
        fin_max_s     = QNAN;
        fin_min_idx_s = IDX_ZERO;
        fin_max_idx_s = IDX_ZERO;
`ifdef FP32_MINMAX_NAN_PROP_EN
        if (nxt_nan_s) begin
            fin_min_idx_s = nxt_nan_idx_s;
            fin_max_idx_s = nxt_nan_idx_s;
        end else if (nxt_have_s) begin
            fin_min_s     = nxt_min_s;
            fin_max_s     = nxt_max_s;
            fin_min_idx_s = nxt_min_idx_s;
            fin_max_idx_s = nxt_max_idx_s;
        end else begin
            fin_min_idx_s = IDX_ZERO;
            fin_max_idx_s = IDX_ZERO;
        end
`else
        // An all-NaN frame keeps the canonical quiet NaN with index 0.
        if (nxt_have_s) begin
            fin_min_s     = nxt_min_s;
            fin_max_s     = nxt_max_s;
            fin_min_idx_s = nxt_min_idx_s;
            fin_max_idx_s = nxt_max_idx_s;
        end else begin
            fin_min_idx_s = IDX_ZERO;
            fin_max_idx_s = IDX_ZERO;
        end
`endif
    end

    // State, frame accumulators and registered result beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_ACC;
            acc_min_r     <= 32'd0;
            acc_max_r     <= 32'd0;
            acc_min_idx_r <= IDX_ZERO;
            acc_max_idx_r <= IDX_ZERO;
            acc_count_r   <= IDX_ZERO;
            acc_nan_idx_r <= IDX_ZERO;
            acc_have_r    <= 1'b0;
            acc_nan_r     <= 1'b0;
            res_min_r     <= 32'd0;
            res_max_r     <= 32'd0;
            res_min_idx_r <= IDX_ZERO;
            res_max_idx_r <= IDX_ZERO;
            res_count_r   <= IDX_ZERO;
            res_nan_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        acc_min_r     <= nxt_min_s;
                        acc_max_r     <= nxt_max_s;
                        acc_min_idx_r <= nxt_min_idx_s;
                        acc_max_idx_r <= nxt_max_idx_s;
                        acc_count_r   <= nxt_count_s;
                        acc_nan_idx_r <= nxt_nan_idx_s;
                        acc_have_r    <= nxt_have_s;
                        acc_nan_r     <= nxt_nan_s;
                        if (bus.s_last) begin
                            res_min_r     <= fin_min_s;
                            res_max_r     <= fin_max_s;
                            res_min_idx_r <= fin_min_idx_s;
                            res_max_idx_r <= fin_max_idx_s;
                            res_count_r   <= nxt_count_s;
                            res_nan_r     <= nxt_nan_s;
                            state_r       <= ST_HOLD;
                        end else begin
                            state_r       <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (bus.m_ready) begin
                        acc_min_r     <= 32'd0;
                        acc_max_r     <= 32'd0;
                        acc_min_idx_r <= IDX_ZERO;
                        acc_max_idx_r <= IDX_ZERO;
                        acc_count_r   <= IDX_ZERO;
                        acc_nan_idx_r <= IDX_ZERO;
                        acc_have_r    <= 1'b0;
                        acc_nan_r     <= 1'b0;
                        state_r       <= ST_ACC;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.s_ready    = (state_r == ST_ACC);
    assign bus.m_valid    = (state_r == ST_HOLD);
    assign bus.m_min      = res_min_r;
    assign bus.m_max      = res_max_r;
    assign bus.m_min_idx  = res_min_idx_r;
    assign bus.m_max_idx  = res_max_idx_r;
    assign bus.m_count    = res_count_r;
    assign bus.m_nan_seen = res_nan_r;

endmodule

// File: tb/tb_fp32_minmax_acc.sv
// ---------------------------------------------------------------------------
// tb_fp32_minmax_acc
//   Self-checking bench for fp32_minmax_acc: directed vector table, directed
//   multi-cycle sequences (stall, reset mid-frame, count saturation) and
//   random frames checked against a real-valued reference model.
// ---------------------------------------------------------------------------
module tb_fp32_minmax_acc;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_minmax_acc_if #(.IDX_W(16)) bus ();

    fp32_minmax_acc #(.IDX_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0][31:0] d;
        int               len;
        logic [31:0]      emin;
        logic [31:0]      emax;
        logic [15:0]      emin_idx;
        logic [15:0]      emax_idx;
        logic [15:0]      ecount;
        logic             enan;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] d0, d1, d2, d3, input int len,
                           input logic [31:0] emin, emax, input logic [15:0] imin, imax,
                           input logic enan);
        vec_t v;
        v.d = {d3, d2, d1, d0};
        v.len = len;
        v.emin = emin; v.emax = emax;
        v.emin_idx = imin; v.emax_idx = imax;
        v.ecount = 16'(len);
        v.enan = enan;
        vecs.push_back(v);
    endtask

    // fp32 bit pattern to real; infinities become values beyond fp32 range.
    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0)        v = real'(b[22:0]) * (2.0 ** (-149));
        else if (e == 255) v = 1.0e39;
        else               v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    function automatic void ref_model(input logic [31:0] q[$],
                                      output logic [31:0] emin, output logic [31:0] emax,
                                      output logic [15:0] imin, output logic [15:0] imax,
                                      output logic [15:0] cnt, output logic enan);
        real lo, hi, r;
        bit  have;
        int  first_nan;
        have = 0; first_nan = -1; lo = 0.0; hi = 0.0;
        emin = QNAN; emax = QNAN; imin = 16'd0; imax = 16'd0; enan = 1'b0;
        cnt = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
        for (int i = 0; i < q.size(); i++) begin
            if (is_nan(q[i])) begin
                enan = 1'b1;
                if (first_nan < 0) first_nan = i;
            end else begin
                r = f2r(q[i]);
                if (!have || r < lo) begin lo = r; emin = q[i]; imin = 16'(i); end
                if (!have || r > hi) begin hi = r; emax = q[i]; imax = 16'(i); end
                have = 1;
            end
        end
`ifdef FP32_MINMAX_NAN_PROP_EN
        if (enan) begin
            emin = QNAN; emax = QNAN;
            imin = 16'(first_nan); imax = 16'(first_nan);
        end
`endif
    endfunction

    function automatic logic [31:0] rand_fp();
        int cat;
        cat = int'($urandom_range(0, 9));
        case (cat)
            0: return {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
            1: return {1'($urandom), 31'd0};
            2: return {1'($urandom), 8'hFF, 23'd0};
            3: return {1'($urandom), 8'd0, 23'($urandom)};
            4, 5: return {1'($urandom), 8'h7F, 2'($urandom), 21'd0};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        t = 0;
        while (!bus.s_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk("s_ready_before_beat", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] q[$], input int max_gap);
        for (int i = 0; i < q.size(); i++) begin
            send_beat(q[i], (i == q.size() - 1), int'($urandom_range(0, max_gap)));
        end
        chk("m_valid_latency", {31'd0, bus.m_valid}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] emin, emax,
                                input logic [15:0] imin, imax, cnt, input logic enan);
        chk({tag, "_min"},     bus.m_min, emin);
        chk({tag, "_max"},     bus.m_max, emax);
        chk({tag, "_min_idx"}, {16'd0, bus.m_min_idx}, {16'd0, imin});
        chk({tag, "_max_idx"}, {16'd0, bus.m_max_idx}, {16'd0, imax});
        chk({tag, "_count"},   {16'd0, bus.m_count},   {16'd0, cnt});
        chk({tag, "_nan"},     {31'd0, bus.m_nan_seen}, {31'd0, enan});
    endtask

    task automatic take_result(input string tag, input logic [31:0] emin, emax,
                               input logic [15:0] imin, imax, cnt, input logic enan,
                               input int stall);
        check_result(tag, emin, emax, imin, imax, cnt, enan);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_m_valid"}, {31'd0, bus.m_valid}, 32'd1);
            chk({tag, "_stall_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
            check_result({tag, "_stall"}, emin, emax, imin, imax, cnt, enan);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        chk({tag, "_post_s_ready"}, {31'd0, bus.s_ready}, 32'd1);
        chk({tag, "_post_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] emin, emax;
        logic [15:0] imin, imax, cnt;
        logic        enan;

        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 32'd0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check_result("rst", 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 1'b0);

        add_vec(32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F000000, 4,
                32'hC0000000, 32'h40600000, 16'd1, 16'd2, 1'b0);
        add_vec(32'h00000000, 32'h80000000, 32'd0, 32'd0, 2,
                32'h00000000, 32'h00000000, 16'd0, 16'd0, 1'b0);
        add_vec(32'h80000000, 32'h00000000, 32'd0, 32'd0, 2,
                32'h80000000, 32'h80000000, 16'd0, 16'd0, 1'b0);
`ifdef FP32_MINMAX_NAN_PROP_EN
        add_vec(32'h7FC00001, 32'h40000000, 32'hFF800000, 32'd0, 3,
                QNAN, QNAN, 16'd0, 16'd0, 1'b1);
        add_vec(32'h3F800000, 32'h7F800001, 32'hFFC00000, 32'd0, 3,
                QNAN, QNAN, 16'd1, 16'd1, 1'b1);
`else
        add_vec(32'h7FC00001, 32'h40000000, 32'hFF800000, 32'd0, 3,
                32'hFF800000, 32'h40000000, 16'd2, 16'd1, 1'b1);
        add_vec(32'h3F800000, 32'h7F800001, 32'hFFC00000, 32'd0, 3,
                32'h3F800000, 32'h3F800000, 16'd0, 16'd0, 1'b1);
`endif
        add_vec(32'h7F800001, 32'hFFC00000, 32'd0, 32'd0, 2,
                QNAN, QNAN, 16'd0, 16'd0, 1'b1);
        add_vec(32'h7F800000, 32'h3F800000, 32'h7F800000, 32'd0, 3,
                32'h3F800000, 32'h7F800000, 16'd1, 16'd0, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].d[i]);
            send_frame(q, 0);
            take_result($sformatf("vec%0d", v), vecs[v].emin, vecs[v].emax,
                        vecs[v].emin_idx, vecs[v].emax_idx, vecs[v].ecount, vecs[v].enan, 0);
        end

        // Single element with a 5-cycle downstream stall.
        q.delete(); q.push_back(32'h40A00000);
        send_frame(q, 0);
        take_result("stall", 32'h40A00000, 32'h40A00000, 16'd0, 16'd0, 16'd1, 1'b0, 5);

        // Reset after two beats of a frame discards them.
        send_beat(32'hC1200000, 1'b0, 0);
        send_beat(32'h7FC00001, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        q.delete(); q.push_back(32'h40E00000);
        send_frame(q, 0);
        take_result("midrst", 32'h40E00000, 32'h40E00000, 16'd0, 16'd0, 16'd1, 1'b0, 0);

        // Reset while a result is pending.
        q.delete(); q.push_back(32'h3F800000); q.push_back(32'h40000000);
        send_frame(q, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("holdrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check_result("holdrst", 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 1'b0);

        // Count saturation: 2^16 + 3 beats of 1.0 back to back.
        chk("sat_s_ready", {31'd0, bus.s_ready}, 32'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h3F800000;
        for (int i = 0; i < 65539; i++) begin
            bus.s_last = (i == 65538);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("sat_m_valid", {31'd0, bus.m_valid}, 32'd1);
        take_result("sat", 32'h3F800000, 32'h3F800000, 16'd0, 16'd0, 16'hFFFF, 1'b0, 0);

        // Random frames against the reference model.
        for (int f = 0; f < 80; f++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) q.push_back(rand_fp());
            ref_model(q, emin, emax, imin, imax, cnt, enan);
            send_frame(q, 2);
            take_result($sformatf("rnd%0d", f), emin, emax, imin, imax, cnt, enan,
                        int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
